// File: rtl/tribuf_bus_arbiter_if.sv
// Request/grant bundle between the tristate bus drivers and the arbiter.
interface tribuf_bus_arbiter_if #(
   parameter int unsigned N = 4
) ();
   localparam int unsigned OW = $clog2(N);

   logic [N-1:0]  req;
   logic [N-1:0]  gnt;
   logic          bus_busy;
   logic [OW-1:0] owner;
   logic          turn;

   // Requester side: raises req, watches the enables
   modport master (
      output req,
      input  gnt,
      input  bus_busy,
      input  owner,
      input  turn
   );

   // Arbiter side: samples req, drives the registered enables
   modport slave (
      input  req,
      output gnt,
      output bus_busy,
      output owner,
      output turn
   );
endinterface

// File: rtl/tribuf_bus_arbiter.sv
// Round-robin owner of the tristate bus output enables. Guarantees at most
// one enable per cycle, a fixed idle gap between tenures and a per-tenure cap.
// Every enable comes straight from a flop so drivers never see select glitches.
module tribuf_bus_arbiter #(
   parameter int unsigned N          = 4,
   parameter int unsigned MAX_HOLD   = 8,
   parameter int unsigned TURNAROUND = 1,
   parameter int unsigned CW         = 8
) (
   input logic                clk,
   input logic                rst_n,
   tribuf_bus_arbiter_if.slave bus
);
   localparam int unsigned OW = $clog2(N);
   localparam int unsigned TW = 4;

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      TURN
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [OW-1:0] ptr;
   logic [OW-1:0] ptr_nxt;
   logic [OW-1:0] owner_q;
   logic [OW-1:0] owner_nxt;
   logic [CW-1:0] hold_cnt;
   logic [CW-1:0] hold_nxt;
   logic [TW-1:0] ta_cnt;
   logic [TW-1:0] ta_nxt;
   logic [N-1:0]  gnt_q;
   logic [N-1:0]  gnt_nxt;
   logic          busy_q;
   logic          busy_nxt;
   logic          turn_q;
   logic          turn_nxt;

   logic          found_c;
   logic [OW-1:0] win_c;
   logic [OW:0]   cand_c;

   // First requesting index at or above the pointer, wrapping modulo N
   always_comb begin
      found_c = 1'b0;
      win_c   = '0;
      cand_c  = '0;
      for (int unsigned i = 0; i < N; i++) begin
         cand_c = {1'b0, ptr} + (OW+1)'(i);
         if (cand_c >= (OW+1)'(N)) begin
            cand_c = cand_c - (OW+1)'(N);
         end
         if (!found_c && bus.req[cand_c[OW-1:0]]) begin
            found_c = 1'b1;
            win_c   = cand_c[OW-1:0];
         end
      end
   end

   // State and registered outputs; reset drops every enable immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         ptr      <= '0;
         owner_q  <= '0;
         hold_cnt <= '0;
         ta_cnt   <= '0;
         gnt_q    <= '0;
         busy_q   <= 1'b0;
         turn_q   <= 1'b0;
      end else begin
         state    <= state_nxt;
         ptr      <= ptr_nxt;
         owner_q  <= owner_nxt;
         hold_cnt <= hold_nxt;
         ta_cnt   <= ta_nxt;
         gnt_q    <= gnt_nxt;
         busy_q   <= busy_nxt;
         turn_q   <= turn_nxt;
      end
   end

   // Next state: grant, hold/release, then count out the turnaround gap
   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      owner_nxt = owner_q;
      hold_nxt  = hold_cnt;
      ta_nxt    = ta_cnt;
      gnt_nxt   = gnt_q;
      busy_nxt  = busy_q;
      turn_nxt  = turn_q;

      unique case (state)
         IDLE: begin
            if (found_c) begin
               state_nxt = GRANT;
               gnt_nxt   = N'(1) << win_c;
               busy_nxt  = 1'b1;
               owner_nxt = win_c;
               hold_nxt  = CW'(1);
               ptr_nxt   = (win_c == OW'(N - 1)) ? '0 : win_c + OW'(1);
            end
         end

         GRANT: begin
            // Owner drop and hold limit on the same edge give one release
            if (!bus.req[owner_q] || (hold_cnt == CW'(MAX_HOLD))) begin
               state_nxt = TURN;
               gnt_nxt   = '0;
               busy_nxt  = 1'b0;
               turn_nxt  = 1'b1;
               ta_nxt    = TW'(TURNAROUND);
            end else begin
               hold_nxt  = hold_cnt + CW'(1);
            end
         end

         TURN: begin
            ta_nxt = ta_cnt - TW'(1);
            if (ta_cnt == TW'(1)) begin
               turn_nxt = 1'b0;
               if (found_c) begin
                  state_nxt = GRANT;
                  gnt_nxt   = N'(1) << win_c;
                  busy_nxt  = 1'b1;
                  owner_nxt = win_c;
                  hold_nxt  = CW'(1);
                  ptr_nxt   = (win_c == OW'(N - 1)) ? '0 : win_c + OW'(1);
               end else begin
                  state_nxt = IDLE;
               end
            end
         end

         default: begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
            busy_nxt  = 1'b0;
            turn_nxt  = 1'b0;
         end
      endcase
   end

   assign bus.gnt      = gnt_q;
   assign bus.bus_busy = busy_q;
   assign bus.owner    = owner_q;
   assign bus.turn     = turn_q;

endmodule

// File: tb/tb_tribuf_bus_arbiter.sv
// Bench for tribuf_bus_arbiter: two instances (turnaround 1 and 3) checked
// against a timestamp-based tenure model, plus constant vector tables.
module tb_tribuf_bus_arbiter;
   localparam int unsigned N    = 4;
   localparam int          MAXH = 8;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   tribuf_bus_arbiter_if #(.N(N)) bus0 ();
   tribuf_bus_arbiter_if #(.N(N)) bus1 ();

   tribuf_bus_arbiter #(.N(N), .MAX_HOLD(8), .TURNAROUND(1), .CW(8)) dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus0)
   );

   tribuf_bus_arbiter #(.N(N), .MAX_HOLD(8), .TURNAROUND(3), .CW(8)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [3:0] req;
      logic [3:0] gnt;
      logic       busy;
      logic [1:0] owner;
      logic       turn;
   } vec_t;

   vec_t vecs[$];

   // Model: 0 idle, 1 someone owns the bus, 2 inside the idle gap
   int m_phase[2];
   int m_owner[2];
   int m_start[2];
   int m_rel[2];
   int m_ptr[2];
   int m_edge[2];

   function automatic int ta_of(input int d);
      return (d == 0) ? 1 : 3;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] dut_gnt(input int d);
      return (d == 0) ? 32'(bus0.gnt) : 32'(bus1.gnt);
   endfunction
   function automatic logic [31:0] dut_busy(input int d);
      return (d == 0) ? 32'(bus0.bus_busy) : 32'(bus1.bus_busy);
   endfunction
   function automatic logic [31:0] dut_owner(input int d);
      return (d == 0) ? 32'(bus0.owner) : 32'(bus1.owner);
   endfunction
   function automatic logic [31:0] dut_turn(input int d);
      return (d == 0) ? 32'(bus0.turn) : 32'(bus1.turn);
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_phase[d] = 0;
         m_owner[d] = 0;
         m_start[d] = 0;
         m_rel[d]   = 0;
         m_ptr[d]   = 0;
         m_edge[d]  = 0;
      end
   endtask

   // Advance the model by one rising edge with requests r
   task automatic model_step(input int d, input logic [3:0] r);
      int e;
      int c;
      m_edge[d]++;
      e = m_edge[d];
      if (m_phase[d] == 1) begin
         if (!r[m_owner[d]] || (e - m_start[d]) == MAXH) begin
            m_phase[d] = 2;
            m_rel[d]   = e;
         end
      end else begin
         if (m_phase[d] == 2 && (e - m_rel[d]) == ta_of(d)) m_phase[d] = 0;
         if (m_phase[d] == 0) begin
            for (int k = 0; k < int'(N); k++) begin
               c = (m_ptr[d] + k) % int'(N);
               if (m_phase[d] == 0 && r[c]) begin
                  m_phase[d] = 1;
                  m_owner[d] = c;
                  m_start[d] = e;
                  m_ptr[d]   = (c + 1) % int'(N);
               end
            end
         end
      end
   endtask

   task automatic check_model();
      logic [31:0] eg;
      for (int d = 0; d < 2; d++) begin
         eg = (m_phase[d] == 1) ? (32'd1 << m_owner[d]) : 32'd0;
         chk($sformatf("d%0d gnt", d), dut_gnt(d), eg);
         chk($sformatf("d%0d bus_busy", d), dut_busy(d), 32'(m_phase[d] == 1));
         chk($sformatf("d%0d owner", d), dut_owner(d), 32'(m_owner[d]));
         chk($sformatf("d%0d turn", d), dut_turn(d), 32'(m_phase[d] == 2));
         chk($sformatf("d%0d onehot", d), 32'($countones(dut_gnt(d)) <= 1), 32'd1);
      end
   endtask

   // Drive requests, take one edge, sample 1 time unit later
   task automatic step(input logic [3:0] r0, input logic [3:0] r1);
      bus0.req = r0;
      bus1.req = r1;
      @(posedge clk);
      model_step(0, r0);
      model_step(1, r1);
      #1;
      check_model();
   endtask

   task automatic do_reset();
      #2;
      rst_n    = 1'b0;
      bus0.req = '0;
      bus1.req = '0;
      model_reset();
      #4;
      chk("reset gnt0", 32'(bus0.gnt), 32'd0);
      chk("reset gnt1", 32'(bus1.gnt), 32'd0);
      rst_n = 1'b1;
   endtask

   task automatic add_vec(input logic [3:0] r, input logic [3:0] g, input logic b,
                          input logic [1:0] o, input logic t);
      vec_t v;
      v.req = r; v.gnt = g; v.busy = b; v.owner = o; v.turn = t;
      vecs.push_back(v);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] r0;
      logic [3:0] r1;
      logic [3:0] g;
      logic [3:0] prev;
      int         cnt;
      int         order[$];
      int         exp_order[5] = '{0, 1, 2, 3, 0};
      logic [3:0] ta3_req[6] = '{4'b1001, 4'b1001, 4'b1000, 4'b1000, 4'b1000, 4'b1000};
      logic [3:0] ta3_gnt[6] = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b1000};
      logic       ta3_trn[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

      // Short burst on req[2], then hold-limit tenures on req[1]
      add_vec(4'b0100, 4'b0100, 1'b1, 2'd2, 1'b0);
      add_vec(4'b0100, 4'b0100, 1'b1, 2'd2, 1'b0);
      add_vec(4'b0100, 4'b0100, 1'b1, 2'd2, 1'b0);
      add_vec(4'b0000, 4'b0000, 1'b0, 2'd2, 1'b1);
      add_vec(4'b0000, 4'b0000, 1'b0, 2'd2, 1'b0);
      for (int i = 0; i < 8; i++) add_vec(4'b0010, 4'b0010, 1'b1, 2'd1, 1'b0);
      add_vec(4'b0010, 4'b0000, 1'b0, 2'd1, 1'b1);
      for (int i = 0; i < 8; i++) add_vec(4'b0010, 4'b0010, 1'b1, 2'd1, 1'b0);
      add_vec(4'b0000, 4'b0000, 1'b0, 2'd1, 1'b1);
      add_vec(4'b0000, 4'b0000, 1'b0, 2'd1, 1'b0);
      add_vec(4'b0000, 4'b0000, 1'b0, 2'd1, 1'b0);

      // Reset with every request high
      rst_n    = 1'b0;
      bus0.req = 4'b1111;
      bus1.req = 4'b1111;
      model_reset();
      #22;
      chk("rst gnt", 32'(bus0.gnt), 32'd0);
      chk("rst bus_busy", 32'(bus0.bus_busy), 32'd0);
      chk("rst turn", 32'(bus0.turn), 32'd0);
      chk("rst owner", 32'(bus0.owner), 32'd0);
      bus0.req = '0;
      bus1.req = '0;
      rst_n    = 1'b1;
      for (int i = 0; i < 10; i++) step(4'b0000, 4'b0000);

      // Constant vector table on instance 0
      foreach (vecs[i]) begin
         step(vecs[i].req, 4'b0000);
         chk($sformatf("vec%0d gnt", i), 32'(bus0.gnt), 32'(vecs[i].gnt));
         chk($sformatf("vec%0d busy", i), 32'(bus0.bus_busy), 32'(vecs[i].busy));
         chk($sformatf("vec%0d owner", i), 32'(bus0.owner), 32'(vecs[i].owner));
         chk($sformatf("vec%0d turn", i), 32'(bus0.turn), 32'(vecs[i].turn));
      end

      // Round robin: everyone requests, each owner drops after 2 cycles
      do_reset();
      r0   = 4'b1111;
      prev = '0;
      cnt  = 0;
      for (int i = 0; i < 60 && order.size() < 5; i++) begin
         step(r0, 4'b0000);
         g = bus0.gnt;
         if (g != 0 && prev == 0) begin
            order.push_back(int'(bus0.owner));
            cnt = 1;
         end else if (g != 0) begin
            cnt++;
         end
         r0   = (g != 0 && cnt == 2) ? (4'b1111 & ~g) : 4'b1111;
         prev = g;
      end
      chk("rr tenures", 32'(order.size()), 32'd5);
      for (int i = 0; i < 5 && i < order.size(); i++)
         chk($sformatf("rr order%0d", i), 32'(order[i]), 32'(exp_order[i]));

      // Turnaround of 3 on instance 1
      do_reset();
      for (int i = 0; i < 6; i++) begin
         step(4'b0000, ta3_req[i]);
         chk($sformatf("ta3 gnt%0d", i), 32'(bus1.gnt), 32'(ta3_gnt[i]));
         chk($sformatf("ta3 turn%0d", i), 32'(bus1.turn), 32'(ta3_trn[i]));
      end

      // Reset pulse in the middle of owner 3's tenure
      do_reset();
      step(4'b1000, 4'b0000);
      step(4'b1000, 4'b0000);
      chk("mid owner before", 32'(bus0.owner), 32'd3);
      #3;
      rst_n = 1'b0;
      #1;
      chk("mid async gnt", 32'(bus0.gnt), 32'd0);
      chk("mid async busy", 32'(bus0.bus_busy), 32'd0);
      model_reset();
      bus0.req = 4'b1010;
      #2;
      rst_n = 1'b1;
      step(4'b1010, 4'b0000);
      chk("mid regrant gnt", 32'(bus0.gnt), 32'b0010);
      chk("mid regrant owner", 32'(bus0.owner), 32'd1);

      // Random sticky requests on both instances against the model
      r0 = 4'b0000;
      r1 = 4'b0000;
      for (int i = 0; i < 800; i++) begin
         r0 = r0 ^ (4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
         r1 = r1 ^ (4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
         step(r0, r1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
